timecode_bcd_seq: RTL and testbench

//  Multi-channel, sequential centisecond-count to HH:MM:SS:CC BCD converter with

---
 rtl/timecode_bcd_seq_if.sv | 26 ++
 rtl/timecode_bcd_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_timecode_bcd_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timecode_bcd_seq_if.sv
// Handshake and data bundle for timecode_bcd_seq.
// master: the requester (drives counts, channel select and start).
// slave : the converter (returns busy/done and the registered BCD result).
interface timecode_bcd_seq_if #(
  parameter int NCH   = 2,
  parameter int SEL_W = 1
);
  logic [NCH*32-1:0] ch_in;
  logic [SEL_W-1:0]  ch_sel;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       bcd_out;
  logic              ovf;
  logic [7:0]        blank;

  modport master (
    output ch_in, ch_sel, start,
    input  busy, done, bcd_out, ovf, blank
  );

  modport slave (
    input  ch_in, ch_sel, start,
    output busy, done, bcd_out, ovf, blank
  );
endinterface

// File: rtl/timecode_bcd_seq.sv
// timecode_bcd_seq: multi-channel centisecond count -> HH:MM:SS:CC BCD converter.
// Converts by repeated subtraction (hours, then minutes, then seconds), then
// splits each binary field into two BCD digits. Counts of 100 h or more
// saturate to 99:59:59:99 with ovf set. Results are held until the next done.
// Optional build macro: LEADING_ZERO_BLANK_EN enables the leading-zero blank
// mask on H1..S1; without it blank is constant zero.
module timecode_bcd_seq #(
  parameter int NCH   = 2,
  parameter int SEL_W = 1
) (
  input logic          clk,
  input logic          rst,
  timecode_bcd_seq_if.slave bus
);

  localparam logic [31:0] SAT_LIMIT   = 32'd36_000_000;
  localparam logic [31:0] HOUR_CS     = 32'd360_000;
  localparam logic [31:0] MIN_CS      = 32'd6_000;
  localparam logic [31:0] SEC_CS      = 32'd100;
  localparam logic [31:0] SAT_PATTERN = 32'h9959_5999;

  typedef enum logic [2:0] {
    IDLE,
    HRS,
    MIN,
    SEC,
    SPLIT,
    SAT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] rem_reg, rem_next;
  logic [6:0]  h_reg, h_next;
  logic [6:0]  m_reg, m_next;
  logic [6:0]  s_reg, s_next;
  logic        sat_wait_reg, sat_wait_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] bcd_reg, bcd_next;
  logic        ovf_reg, ovf_next;
  logic        accept;
  logic [31:0] sel_word;
  logic [31:0] split_word;
  logic [31:0] ch_word [NCH];

  // Binary 0..99 to two BCD digits by bounded repeated subtraction of ten.
  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] ones;
    tens = 4'd0;
    ones = v;
    for (int k = 0; k < 9; k++) begin
      if (ones >= 7'd10) begin
        ones = ones - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, ones[3:0]};
  endfunction

  // Unpack the flat channel bus into one 32-bit word per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_word[gi] = bus.ch_in[32*gi +: 32];
  end

  // Channel mux; an out-of-range select falls back to channel 0.
  always_comb begin
    sel_word = ch_word[0];
    for (int k = 1; k < NCH; k++) begin
      if (int'(bus.ch_sel) == k) begin
        sel_word = ch_word[k];
      end
    end
  end

  // In SPLIT the remainder is below 100, so its low 7 bits are the centiseconds.
  assign split_word = {to_bcd2(h_reg), to_bcd2(m_reg), to_bcd2(s_reg), to_bcd2(rem_reg[6:0])};

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank_reg, blank_next;

  // Blank leading zero digits from H1 down; S0, C1 and C0 always stay lit.
  function automatic logic [7:0] lead_blank(input logic [31:0] d);
    logic [7:0] m;
    logic       lead;
    m    = 8'h00;
    lead = 1'b1;
    for (int i = 7; i >= 3; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) begin
        m[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
    return m;
  endfunction

  // Blank mask register, updated only alongside bcd_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_reg <= 8'h00;
    end else begin
      blank_reg <= blank_next;
    end
  end

  assign bus.blank = blank_reg;
`else
  assign bus.blank = 8'h00;
`endif

  // Next-state and datapath: subtraction loop, digit split, saturation and accept.
  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    h_next        = h_reg;
    m_next        = m_reg;
    s_next        = s_reg;
    sat_wait_next = sat_wait_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;
`ifdef LEADING_ZERO_BLANK_EN
    blank_next    = blank_reg;
`endif
    accept        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        accept = bus.start;
      end
      HRS: begin
        if (rem_reg >= HOUR_CS) begin
          rem_next = rem_reg - HOUR_CS;
          h_next   = h_reg + 7'd1;
        end else begin
          state_next = MIN;
        end
      end
      MIN: begin
        if (rem_reg >= MIN_CS) begin
          rem_next = rem_reg - MIN_CS;
          m_next   = m_reg + 7'd1;
        end else begin
          state_next = SEC;
        end
      end
      SEC: begin
        if (rem_reg >= SEC_CS) begin
          rem_next = rem_reg - SEC_CS;
          s_next   = s_reg + 7'd1;
        end else begin
          state_next = SPLIT;
        end
      end
      SPLIT: begin
        bcd_next   = split_word;
        ovf_next   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank_next = lead_blank(split_word);
`endif
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
        // The edge that returns to IDLE may also take the next request.
        accept     = bus.start;
      end
      SAT: begin
        // Overflow path spends one wait cycle so its latency is a fixed two edges.
        if (sat_wait_reg) begin
          sat_wait_next = 1'b0;
        end else begin
          bcd_next   = SAT_PATTERN;
          ovf_next   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          blank_next = 8'h00;
`endif
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
          accept     = bus.start;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      rem_next  = sel_word;
      h_next    = 7'd0;
      m_next    = 7'd0;
      s_next    = 7'd0;
      busy_next = 1'b1;
      if (sel_word >= SAT_LIMIT) begin
        state_next    = SAT;
        sat_wait_next = 1'b1;
      end else begin
        state_next    = HRS;
        sat_wait_next = 1'b0;
      end
    end
  end

  // State and datapath registers; reset aborts any conversion without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rem_reg      <= 32'd0;
      h_reg        <= 7'd0;
      m_reg        <= 7'd0;
      s_reg        <= 7'd0;
      sat_wait_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= 32'd0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      h_reg        <= h_next;
      m_reg        <= m_next;
      s_reg        <= s_next;
      sat_wait_reg <= sat_wait_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.bcd_out = bcd_reg;
  assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_timecode_bcd_seq.sv
// Self-checking bench for timecode_bcd_seq. Expected results come from a
// division-based reference of the HH:MM:SS:CC rules; three channels and a
// 2-bit select are used so an out-of-range select can be exercised.
module tb_timecode_bcd_seq;
  localparam int NCH   = 3;
  localparam int SEL_W = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic acc_busy;

  timecode_bcd_seq_if #(.NCH(NCH), .SEL_W(SEL_W)) bus ();

  timecode_bcd_seq #(.NCH(NCH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: time fields by division, latency from the field counts.
  function automatic void ref_model(input logic [31:0] v, output logic [31:0] bcd,
                                    output logic ovf, output logic [7:0] blank,
                                    output int lat);
    int unsigned hh, mm, ss, cc;
    blank = 8'h00;
    if (v >= 32'd36_000_000) begin
      bcd = 32'h9959_5999;
      ovf = 1'b1;
      lat = 2;
      return;
    end
    hh  = v / 360_000;
    mm  = (v % 360_000) / 6_000;
    ss  = (v % 6_000) / 100;
    cc  = v % 100;
    lat = int'(hh + mm + ss) + 4;
    ovf = 1'b0;
    bcd = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
           4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 7; i >= 3; i--) begin
      if (bcd[4*i +: 4] != 4'd0) break;
      blank[i] = 1'b1;
    end
`endif
  endfunction

  function automatic int eff_ch(input logic [SEL_W-1:0] sel);
    return (int'(sel) < NCH) ? int'(sel) : 0;
  endfunction

  // One start pulse; returns edges from accept to done (timeout flagged).
  task automatic do_conv(input logic [SEL_W-1:0] sel, input bit scramble,
                         output int lat, output bit to);
    int cnt;
    @(negedge clk);
    bus.ch_sel = sel;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    acc_busy = bus.busy;
    @(negedge clk);
    bus.start = 1'b0;
    if (scramble) begin
      for (int k = 0; k < NCH; k++) bus.ch_in[32*k +: 32] = $urandom;
    end
    cnt = 0;
    to  = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done) break;
      if (cnt > 400) begin
        to = 1'b1;
        break;
      end
    end
    lat = cnt;
  endtask

  task automatic test_reset();
    bit seen_busy, seen_done;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.ch_sel = '0;
    bus.ch_in  = '0;
    bus.ch_in[31:0] = 32'd12_345;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.start = c[0];
      @(posedge clk);
      #1;
      if (bus.busy) seen_busy = 1'b1;
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=1 want=0"); end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL reset_done got=1 want=0"); end
    checks++;
    if (bus.bcd_out !== 32'h0) begin errors++; $display("FAIL reset_bcd got=%h want=00000000", bus.bcd_out); end
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    checks++;
    if (bus.blank !== 8'h00) begin errors++; $display("FAIL reset_blank got=%h want=00", bus.blank); end
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    $display("reset: held with start pulses, busy=%b done=%b bcd=%h", seen_busy, seen_done, bus.bcd_out);
  endtask

  // Directed values: zero, mixed fields, out-of-range select, boundaries.
  task automatic test_directed();
    logic [31:0]      val_tab [8] = '{32'd0, 32'd372_304, 32'd1_234_567, 32'd359_999,
                                      32'd35_999_999, 32'd36_000_000, 32'hFFFF_FFFF, 32'd99};
    logic [SEL_W-1:0] sel_tab [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3};
    logic [31:0] eb;
    logic        eo;
    logic [7:0]  ebl;
    int          el, lat;
    bit          to;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NCH; k++) bus.ch_in[32*k +: 32] = $urandom_range(0, 40_000_000);
      bus.ch_in[32*eff_ch(sel_tab[n]) +: 32] = val_tab[n];
      ref_model(val_tab[n], eb, eo, ebl, el);
      do_conv(sel_tab[n], 1'b0, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL dir_timeout val=%0d no done within 400 edges", val_tab[n]); end
      checks++;
      if (acc_busy !== 1'b1) begin errors++; $display("FAIL dir_busy_on val=%0d got=%b want=1", val_tab[n], acc_busy); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL dir_latency val=%0d got=%0d want=%0d", val_tab[n], lat, el); end
      checks++;
      if (bus.bcd_out !== eb) begin errors++; $display("FAIL dir_bcd val=%0d got=%h want=%h", val_tab[n], bus.bcd_out, eb); end
      checks++;
      if (bus.ovf !== eo) begin errors++; $display("FAIL dir_ovf val=%0d got=%b want=%b", val_tab[n], bus.ovf, eo); end
      checks++;
      if (bus.blank !== ebl) begin errors++; $display("FAIL dir_blank val=%0d got=%h want=%h", val_tab[n], bus.blank, ebl); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL dir_busy_off val=%0d got=%b want=0", val_tab[n], bus.busy); end
      $display("directed: val=%0d sel=%0d lat=%0d bcd=%h ovf=%b blank=%h", val_tab[n], sel_tab[n], lat, bus.bcd_out, bus.ovf, bus.blank);
    end
  endtask

  // Random counts and selects; channels are scrambled right after accept.
  task automatic test_random();
    logic [31:0]      v;
    logic [SEL_W-1:0] sel;
    logic [31:0]      eb;
    logic             eo;
    logic [7:0]       ebl;
    int               el, lat, r;
    bit               to;
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NCH; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      bus.ch_in[32*k +: 32] = $urandom;
        else if (r == 1) bus.ch_in[32*k +: 32] = 32'(36_000_000 - 3 + $urandom_range(0, 6));
        else             bus.ch_in[32*k +: 32] = $urandom_range(0, 35_999_999);
      end
      sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      v   = bus.ch_in[32*eff_ch(sel) +: 32];
      ref_model(v, eb, eo, ebl, el);
      do_conv(sel, 1'b1, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL rnd_timeout val=%0d no done within 400 edges", v); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL rnd_latency val=%0d got=%0d want=%0d", v, lat, el); end
      checks++;
      if (bus.bcd_out !== eb) begin errors++; $display("FAIL rnd_bcd val=%0d got=%h want=%h", v, bus.bcd_out, eb); end
      checks++;
      if (bus.ovf !== eo) begin errors++; $display("FAIL rnd_ovf val=%0d got=%b want=%b", v, bus.ovf, eo); end
      checks++;
      if (bus.blank !== ebl) begin errors++; $display("FAIL rnd_blank val=%0d got=%h want=%h", v, bus.blank, ebl); end
      $display("random: val=%0d sel=%0d lat=%0d bcd=%h ovf=%b", v, sel, lat, bus.bcd_out, bus.ovf);
    end
  endtask

  // Start held high: one done per conversion period, no extra done.
  task automatic test_back_to_back();
    logic [31:0] eb;
    logic        eo;
    logic [7:0]  ebl;
    int          el, last, ndone, win, cnt;
    bus.ch_in[31:0] = 32'd5_999;
    ref_model(32'd5_999, eb, eo, ebl, el);
    win = 4 * el + 10;
    @(negedge clk);
    bus.ch_sel = '0;
    bus.start  = 1'b1;
    @(posedge clk);
    last  = 0;
    ndone = 0;
    for (int c = 1; c <= win; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        checks++;
        if (c - last != el) begin errors++; $display("FAIL b2b_period got=%0d want=%0d", c - last, el); end
        checks++;
        if (bus.bcd_out !== eb) begin errors++; $display("FAIL b2b_bcd got=%h want=%h", bus.bcd_out, eb); end
        $display("back_to_back: done at edge %0d bcd=%h", c, bus.bcd_out);
        last = c;
      end
    end
    checks++;
    if (ndone != win / el) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", ndone, win / el); end
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain busy still high after 400 edges"); end
  endtask

  // Reset mid-conversion: outputs clear, no done, then a clean restart.
  task automatic test_abort();
    logic [31:0] eb;
    logic        eo;
    logic [7:0]  ebl;
    int          el, lat;
    bit          to, seen_done;
    bus.ch_in[31:0]  = 32'd100;
    bus.ch_in[63:32] = 32'd372_304;
    @(negedge clk);
    bus.ch_sel = 2'd1;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", bus.done); end
    checks++;
    if (bus.bcd_out !== 32'h0) begin errors++; $display("FAIL abort_bcd got=%h want=00000000", bus.bcd_out); end
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b want=0", bus.ovf); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_quiet got=activity want=none"); end
    ref_model(32'd100, eb, eo, ebl, el);
    do_conv(2'd0, 1'b0, lat, to);
    checks++;
    if (to || lat != el) begin errors++; $display("FAIL abort_restart_lat got=%0d want=%0d", lat, el); end
    checks++;
    if (bus.bcd_out !== eb) begin errors++; $display("FAIL abort_restart_bcd got=%h want=%h", bus.bcd_out, eb); end
    $display("abort: restart val=100 lat=%0d bcd=%h", lat, bus.bcd_out);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    acc_busy = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
